mem_port_arbiter: RTL

Shares a single-ported memory bus between the instruction-fetch port and the data-memory port of the pipeline. It sequences one transaction at a time and returns a one-cycle completion pulse to the winning requester. It also produces `InstMem_Ready` and `MEM_Stall_Controller`, which the hazard detection unit consumes to stall IF/MEM. A watchdog terminates transactions the memory never acknowledges.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 90 +++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// master = arbiter view, slave = requester/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
);
  logic                  InstMem_Read;
  logic [ADDR_WIDTH-1:0] InstMem_Address;
  logic [DATA_WIDTH-1:0] InstMem_Data;
  logic                  InstMem_Ready;
  logic                  DataMem_Read;
  logic                  DataMem_Write;
  logic [ADDR_WIDTH-1:0] DataMem_Address;
  logic [DATA_WIDTH-1:0] DataMem_WriteData;
  logic [3:0]            DataMem_ByteEn;
  logic [DATA_WIDTH-1:0] DataMem_ReadData;
  logic                  DataMem_Ready;
  logic                  MEM_Stall_Controller;
  logic                  Mem_Req;
  logic                  Mem_Write;
  logic [ADDR_WIDTH-1:0] Mem_Address;
  logic [DATA_WIDTH-1:0] Mem_WriteData;
  logic [3:0]            Mem_ByteEn;
  logic [DATA_WIDTH-1:0] Mem_ReadData;
  logic                  Mem_Ack;
  logic                  Bus_Error;

  modport master (
    input  InstMem_Read, InstMem_Address,
    input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_WriteData, DataMem_ByteEn,
    input  Mem_ReadData, Mem_Ack,
    output InstMem_Data, InstMem_Ready, DataMem_ReadData, DataMem_Ready, MEM_Stall_Controller,
    output Mem_Req, Mem_Write, Mem_Address, Mem_WriteData, Mem_ByteEn, Bus_Error
  );

  modport slave (
    output InstMem_Read, InstMem_Address,
    output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_WriteData, DataMem_ByteEn,
    output Mem_ReadData, Mem_Ack,
    input  InstMem_Data, InstMem_Ready, DataMem_ReadData, DataMem_Ready, MEM_Stall_Controller,
    input  Mem_Req, Mem_Write, Mem_Address, Mem_WriteData, Mem_ByteEn, Bus_Error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and data access, one
// transaction at a time, round-robin on ties, with a watchdog on missing acks.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic clock,
  input logic reset,
  mem_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, INST_BUSY, DATA_BUSY, DONE} state_t;

  state_t                state;
  logic                  last_grant;  // 1 = data was granted last
  logic [15:0]           wd_cnt;
  logic                  inst_pend, data_pend, grant_data, timeout;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] rdata_cap;

  assign inst_pend  = bus.InstMem_Read;
  assign data_pend  = bus.DataMem_Read | bus.DataMem_Write;
  assign grant_data = data_pend & (~inst_pend | ~last_grant);
  assign grant_addr = grant_data ? bus.DataMem_Address : bus.InstMem_Address;
  assign timeout    = (wd_cnt == 16'(TIMEOUT - 1));
  // Writes and timed-out transactions return zero to the requester.
  assign rdata_cap  = (bus.Mem_Ack & ~bus.Mem_Write) ? bus.Mem_ReadData : '0;

  assign bus.MEM_Stall_Controller = data_pend & ~bus.DataMem_Ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= IDLE;
      last_grant           <= 1'b0;
      wd_cnt               <= '0;
      bus.Mem_Req          <= 1'b0;
      bus.Mem_Write        <= 1'b0;
      bus.Mem_Address      <= '0;
      bus.Mem_WriteData    <= '0;
      bus.Mem_ByteEn       <= '0;
      bus.InstMem_Data     <= '0;
      bus.InstMem_Ready    <= 1'b0;
      bus.DataMem_ReadData <= '0;
      bus.DataMem_Ready    <= 1'b0;
      bus.Bus_Error        <= 1'b0;
    end else begin
      bus.InstMem_Ready <= 1'b0;
      bus.DataMem_Ready <= 1'b0;
      bus.Bus_Error     <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_pend | data_pend) begin
            state           <= grant_data ? DATA_BUSY : INST_BUSY;
            last_grant      <= grant_data;
            wd_cnt          <= '0;
            bus.Mem_Req     <= 1'b1;
            bus.Mem_Address <= grant_addr;
            if (grant_data) begin
              bus.Mem_Write     <= bus.DataMem_Write;
              bus.Mem_WriteData <= bus.DataMem_WriteData;
              bus.Mem_ByteEn    <= bus.DataMem_Write ? bus.DataMem_ByteEn : 4'b1111;
            end else begin
              bus.Mem_Write     <= 1'b0;
              bus.Mem_WriteData <= '0;
              bus.Mem_ByteEn    <= 4'b1111;
            end
          end
        end
        INST_BUSY, DATA_BUSY: begin
          // An ack in the timeout cycle still completes normally.
          if (bus.Mem_Ack | timeout) begin
            state         <= DONE;
            bus.Mem_Req   <= 1'b0;
            bus.Bus_Error <= ~bus.Mem_Ack;
            if (state == DATA_BUSY) begin
              bus.DataMem_ReadData <= rdata_cap;
              bus.DataMem_Ready    <= 1'b1;
            end else begin
              bus.InstMem_Data  <= rdata_cap;
              bus.InstMem_Ready <= 1'b1;
            end
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
